// File: rtl/output_display_pkg.sv
// Shared constants, state types and the 7-segment encoder for the output display.
package output_display_pkg;

  localparam int NUM_DIGITS = 3;
  localparam int BIN_W      = 8;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  // Segment order is {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Glyphs for 0..9, index 0 in the least-significant slot.
  localparam logic [9:0][6:0] SEG_GLYPH = {
    7'h10, // 9
    7'h00, // 8
    7'h78, // 7
    7'h02, // 6
    7'h12, // 5
    7'h19, // 4
    7'h30, // 3
    7'h24, // 2
    7'h79, // 1
    7'h40  // 0
  };

  typedef enum logic {
    CONV_IDLE,
    CONV_SHIFT
  } conv_state_e;

  // Non-decimal codes blank the digit rather than showing garbage.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_GLYPH[d];
  endfunction

endpackage

// File: rtl/output_display_if.sv
// CPU-side value/strobe bus plus the conversion status and committed result.
interface output_display_if;
  import output_display_pkg::*;

  logic [BIN_W-1:0] value_in;
  logic             value_valid;
  logic             busy;
  logic             overwrite;
  logic [BCD_W-1:0] bcd;

  modport master (output value_in, value_valid, input busy, overwrite, bcd);
  modport slave  (input value_in, value_valid, output busy, overwrite, bcd);
endinterface

// File: rtl/output_display_bin2bcd_seq.sv
// Sequential double-dabble: one shift per clock, 8 shifts per conversion.
// done marks the cycle whose closing edge is the final shift; bcd is the
// result that edge produces, so the caller commits bcd when done is high.
module bin2bcd_seq
  import output_display_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_e              state_q, state_d;
  logic [2:0]               cnt_q;
  // {bcd digits, remaining binary bits} shifted as one register.
  logic [BCD_W+BIN_W-1:0]   z_q, z_adj, z_nx;

  // Add 3 to any digit >= 5, then shift the whole register left by one.
  always_comb begin
    z_adj = z_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (z_q[BIN_W + 4*d +: 4] >= 4'd5)
        z_adj[BIN_W + 4*d +: 4] = z_q[BIN_W + 4*d +: 4] + 4'd3;
    end
    z_nx = z_adj << 1;
  end

  assign busy = (state_q == CONV_SHIFT);
  assign done = busy && (cnt_q == 3'd7);
  assign bcd  = z_nx[BIN_W +: BCD_W];

  // Next state: a start on the final shift chains straight into a new run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CONV_IDLE:  if (start) state_d = CONV_SHIFT;
      CONV_SHIFT: if (done)  state_d = start ? CONV_SHIFT : CONV_IDLE;
      default:    state_d = CONV_IDLE;
    endcase
  end

  // State register and datapath: load on start, otherwise shift while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CONV_IDLE;
      cnt_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        z_q   <= {{BCD_W{1'b0}}, bin};
        cnt_q <= '0;
      end else if (busy) begin
        z_q   <= z_nx;
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/output_display.sv
// CPU output register display: binary->BCD conversion with a one-deep
// pending slot, committed result register, and multiplexed 7-segment scan.
module output_display
  import output_display_pkg::*;
#(
  parameter int SCAN_DIV = 4000
) (
  input  logic                  clk,
  input  logic                  reset,
  output_display_if.slave       bus,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic             c_start, c_busy, c_done;
  logic [BIN_W-1:0] c_bin;
  logic [BCD_W-1:0] c_bcd;

  logic [BCD_W-1:0] bcd_q;
  logic [BIN_W-1:0] pend_q;
  logic             pend_vld_q;
  logic             ov_q;

  logic [PW-1:0]    pre_q;
  logic [1:0]       idx_q;
  logic [6:0]       seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  // Start when idle and strobed, or chain at the final shift if work waits.
  // A live strobe at the final shift wins over the pending value.
  always_comb begin
    c_start = !reset && ((bus.value_valid && !c_busy) ||
                         (c_done && (pend_vld_q || bus.value_valid)));
    c_bin   = (c_busy && !bus.value_valid) ? pend_q : bus.value_in;
  end

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (c_start),
    .bin   (c_bin),
    .busy  (c_busy),
    .done  (c_done),
    .bcd   (c_bcd)
  );

  // Commit, pending slot and overwrite pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ov_q       <= 1'b0;
    end else if (c_done) begin
      bcd_q      <= c_bcd;
      pend_vld_q <= 1'b0;
      ov_q       <= pend_vld_q && bus.value_valid;
    end else if (bus.value_valid && c_busy) begin
      pend_q     <= bus.value_in;
      pend_vld_q <= 1'b1;
      ov_q       <= pend_vld_q;
    end else begin
      ov_q       <= 1'b0;
    end
  end

  assign bus.busy      = c_busy;
  assign bus.overwrite = ov_q;
  assign bus.bcd       = bcd_q;

  // Scan prescaler and digit index, ones -> tens -> hundreds.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PW'(SCAN_DIV - 1)) begin
      pre_q <= '0;
      idx_q <= (idx_q == 2'(NUM_DIGITS - 1)) ? 2'd0 : idx_q + 2'd1;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  // Glyph for the active digit with leading-zero blanking.
  always_comb begin
    logic [3:0] h, t, d;
    h     = bcd_q[11:8];
    t     = bcd_q[7:4];
    d     = bcd_q[{idx_q, 2'b00} +: 4];
    an_d  = ~(NUM_DIGITS'(1) << idx_q);
    seg_d = seg_encode(d);
    if ((idx_q == 2'd2 && h == 4'd0) ||
        (idx_q == 2'd1 && h == 4'd0 && t == 4'd0))
      seg_d = SEG_BLANK;
  end

  // Registered display outputs; dark through reset and the cycle after.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= seg_d;
      an  <= an_d;
    end
  end

endmodule

// File: tb/tb_output_display.sv
module tb_output_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg1, seg2;
  logic [2:0] an1, an2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (tracks dut1 only)
  int m_busy, m_left, m_cur, m_pend_vld, m_pend, m_ov, m_bcd;

  output_display_if bus1 ();
  output_display_if bus2 ();

  output_display #(.SCAN_DIV(4)) dut1 (.clk(clk), .reset(reset), .bus(bus1), .seg(seg1), .an(an1));
  output_display #(.SCAN_DIV(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2), .seg(seg2), .an(an2));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int dec(int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  // Expected active-low glyph for digit k (0=ones) of value v.
  function automatic logic [6:0] exp_seg(int v, int k);
    logic [6:0] on_tbl [10];
    int h, t, o, d;
    on_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    if (k == 2 && h == 0) return 7'h7F;
    if (k == 1 && h == 0 && t == 0) return 7'h7F;
    d = (k == 0) ? o : (k == 1) ? t : h;
    return ~on_tbl[d];
  endfunction

  // Behavioural model: strobe starts an 8-edge conversion, one pending slot.
  task automatic model_step(input bit r, input bit v, input int val);
    if (r) begin
      m_busy = 0; m_left = 0; m_cur = 0; m_pend_vld = 0; m_pend = 0; m_ov = 0; m_bcd = 0;
      return;
    end
    m_ov = 0;
    if (!m_busy) begin
      if (v) begin m_cur = val; m_left = 8; m_busy = 1; end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_bcd = dec(m_cur);
        if (v) begin m_ov = m_pend_vld; m_pend_vld = 0; m_cur = val; m_left = 8; end
        else if (m_pend_vld) begin m_cur = m_pend; m_pend_vld = 0; m_left = 8; end
        else m_busy = 0;
      end else if (v) begin
        m_ov = m_pend_vld; m_pend = val; m_pend_vld = 1;
      end
    end
  endtask

  // One clock: drive inputs, edge, model update, settle.
  task automatic cyc(input bit r, input bit v, input int val);
    reset = r;
    bus1.value_valid = v;
    bus1.value_in = 8'(val);
    @(posedge clk);
    model_step(r, v, val);
    #1;
    bus1.value_valid = 1'b0;
  endtask

  task automatic capture(output logic [2:0][6:0] g, output bit ok);
    bit [2:0] seen;
    seen = '0;
    g = '1;
    for (int c = 0; c < 48 && seen != 3'b111; c++) begin
      for (int k = 0; k < 3; k++)
        if (an1 == 3'(~(3'b001 << k))) begin g[k] = seg1; seen[k] = 1'b1; end
      if (seen != 3'b111) cyc(0, 0, 0);
    end
    ok = (seen == 3'b111);
  endtask

  task automatic test_reset();
    cyc(1, 0, 0);
    cyc(1, 1, 55);
    n_tests++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", bus1.busy); end
    n_tests++; if (bus1.overwrite !== 1'b0) begin n_fail++; $display("FAIL rst_ov got %b exp 0", bus1.overwrite); end
    n_tests++; if (bus1.bcd !== 12'h000) begin n_fail++; $display("FAIL rst_bcd got %h exp 000", bus1.bcd); end
    n_tests++; if (seg1 !== 7'h7F || an1 !== 3'b111) begin n_fail++; $display("FAIL rst_disp got %h/%b exp 7f/111", seg1, an1); end
    cyc(0, 0, 0);
    n_tests++; if (an1 !== 3'b110 || seg1 !== exp_seg(0, 0)) begin n_fail++; $display("FAIL first_scan got %h/%b exp %h/110", seg1, an1, exp_seg(0, 0)); end
  endtask

  task automatic test_255();
    logic [2:0][6:0] g; bit ok;
    cyc(0, 1, 255);
    for (int k = 1; k <= 8; k++) begin
      n_tests++; if (bus1.busy !== 1'b1) begin n_fail++; $display("FAIL busy255 edge%0d got %b exp 1", k - 1, bus1.busy); end
      cyc(0, 0, 0);
    end
    n_tests++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL busy255_end got %b exp 0", bus1.busy); end
    n_tests++; if (bus1.bcd !== 12'h255) begin n_fail++; $display("FAIL bcd255 got %h exp 255", bus1.bcd); end
    cyc(0, 0, 0);
    capture(g, ok);
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (!ok || g[k] !== exp_seg(255, k)) begin n_fail++; $display("FAIL glyph255 d%0d got %h exp %h", k, g[k], exp_seg(255, k)); end
    end
  endtask

  task automatic test_7();
    logic [2:0][6:0] g; bit ok;
    cyc(0, 1, 7);
    repeat (8) cyc(0, 0, 0);
    n_tests++; if (bus1.bcd !== 12'h007) begin n_fail++; $display("FAIL bcd7 got %h exp 007", bus1.bcd); end
    cyc(0, 0, 0);
    capture(g, ok);
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (!ok || g[k] !== exp_seg(7, k)) begin n_fail++; $display("FAIL glyph7 d%0d got %h exp %h", k, g[k], exp_seg(7, k)); end
    end
  endtask

  task automatic test_overwrite();
    cyc(0, 1, 13);            // E0
    cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(0, 1, 21);            // E3
    n_tests++; if (bus1.overwrite !== 1'b0) begin n_fail++; $display("FAIL ov_e3 got %b exp 0", bus1.overwrite); end
    cyc(0, 0, 0);
    cyc(0, 1, 34);            // E5
    n_tests++; if (bus1.overwrite !== 1'b1) begin n_fail++; $display("FAIL ov_e5 got %b exp 1", bus1.overwrite); end
    cyc(0, 0, 0);             // E6
    n_tests++; if (bus1.overwrite !== 1'b0) begin n_fail++; $display("FAIL ov_e6 got %b exp 0", bus1.overwrite); end
    cyc(0, 0, 0); cyc(0, 0, 0); // E7, E8
    n_tests++; if (bus1.bcd !== 12'h013 || bus1.busy !== 1'b1) begin n_fail++; $display("FAIL ow_e8 got %h/%b exp 013/1", bus1.bcd, bus1.busy); end
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 0, 0);
      if (k < 8) begin
        n_tests++; if (bus1.bcd !== 12'h013) begin n_fail++; $display("FAIL ow_hold k%0d got %h exp 013", k, bus1.bcd); end
      end
    end
    n_tests++; if (bus1.bcd !== 12'h034 || bus1.busy !== 1'b0) begin n_fail++; $display("FAIL ow_second got %h/%b exp 034/0", bus1.bcd, bus1.busy); end
  endtask

  task automatic test_e8_collision();
    cyc(0, 1, 1);             // E0
    repeat (3) cyc(0, 0, 0);
    cyc(0, 1, 2);             // E4
    n_tests++; if (bus1.overwrite !== 1'b0) begin n_fail++; $display("FAIL e8c_e4 got %b exp 0", bus1.overwrite); end
    repeat (3) cyc(0, 0, 0);
    cyc(0, 1, 2);             // E8
    n_tests++; if (bus1.overwrite !== 1'b1 || bus1.bcd !== 12'h001 || bus1.busy !== 1'b1) begin
      n_fail++; $display("FAIL e8c_e8 got ov=%b bcd=%h busy=%b exp 1/001/1", bus1.overwrite, bus1.bcd, bus1.busy); end
    cyc(0, 0, 0);
    n_tests++; if (bus1.overwrite !== 1'b0) begin n_fail++; $display("FAIL e8c_pulse got %b exp 0", bus1.overwrite); end
    repeat (7) cyc(0, 0, 0);
    n_tests++; if (bus1.bcd !== 12'h002 || bus1.busy !== 1'b0) begin n_fail++; $display("FAIL e8c_done got %h/%b exp 002/0", bus1.bcd, bus1.busy); end
  endtask

  task automatic test_reset_abort();
    cyc(0, 1, 200);
    repeat (3) cyc(0, 0, 0);
    cyc(1, 1, 77);            // reset at E4, strobe must be ignored
    n_tests++; if (bus1.bcd !== 12'h000 || bus1.busy !== 1'b0 || an1 !== 3'b111 || seg1 !== 7'h7F) begin
      n_fail++; $display("FAIL abort got bcd=%h busy=%b an=%b seg=%h exp 000/0/111/7f", bus1.bcd, bus1.busy, an1, seg1); end
    cyc(0, 0, 0);
    n_tests++; if (bus1.busy !== 1'b0 || an1 !== 3'b110) begin n_fail++; $display("FAIL abort_after got busy=%b an=%b exp 0/110", bus1.busy, an1); end
    cyc(0, 1, 200);
    repeat (8) cyc(0, 0, 0);
    n_tests++; if (bus1.bcd !== 12'h200 || bus1.busy !== 1'b0) begin n_fail++; $display("FAIL abort_redo got %h/%b exp 200/0", bus1.bcd, bus1.busy); end
  endtask

  task automatic test_scan();
    logic [2:0] prev;
    bit found;
    int k;
    bus2.value_in = 8'd144;
    bus2.value_valid = 1'b1;
    cyc(0, 0, 0);
    bus2.value_valid = 1'b0;
    repeat (10) cyc(0, 0, 0);
    n_tests++; if (bus2.bcd !== 12'h144) begin n_fail++; $display("FAIL scan_bcd got %h exp 144", bus2.bcd); end
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      prev = an2;
      cyc(0, 0, 0);
      if (an2 == 3'b110 && prev != 3'b110) found = 1'b1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL scan_align got an=%b exp a 110 phase", an2); end
    for (int i = 0; i < 12; i++) begin
      k = (i / 2) % 3;
      n_tests++; if (an2 !== 3'(~(3'b001 << k)) || seg2 !== exp_seg(144, k)) begin
        n_fail++; $display("FAIL scan i%0d got %b/%h exp %b/%h", i, an2, seg2, 3'(~(3'b001 << k)), exp_seg(144, k)); end
      cyc(0, 0, 0);
    end
  endtask

  task automatic test_random();
    bit v; int val;
    cyc(1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 2) == 0);
      val = int'($urandom_range(0, 255));
      cyc(0, v, val);
      n_tests++; if (bus1.busy !== 1'(m_busy) || bus1.overwrite !== 1'(m_ov) || bus1.bcd !== 12'(m_bcd)) begin
        n_fail++; $display("FAIL rand i%0d got busy=%b ov=%b bcd=%h exp %b/%b/%h", i, bus1.busy, bus1.overwrite, bus1.bcd, 1'(m_busy), 1'(m_ov), 12'(m_bcd)); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus1.value_valid = 1'b0; bus1.value_in = '0;
    bus2.value_valid = 1'b0; bus2.value_in = '0;
    test_reset();
    test_255();
    test_7();
    test_overwrite();
    test_e8_collision();
    test_reset_abort();
    test_scan();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/output_display.md
OUTPUT_DISPLAY -- requirements
Module: output_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4000, clk cycles each digit is driven (>=2).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port value_in  input  8  unsigned value from the CPU output register.
REQ-005 SHALL have port value_valid  input  1  one-cycle strobe: value_in is new.
REQ-006 SHALL have port busy  output  1  conversion in progress.
REQ-007 SHALL have port overwrite  output  1  one-cycle pulse: a pending value was discarded.
REQ-008 SHALL have port bcd  output  12  committed result {hundreds, tens, ones}, 4 bits per digit.
REQ-009 SHALL have port seg  output  7  segments {g..a}, active-low.
REQ-010 SHALL have port an  output  3  digit enables, active-low; an[0]=ones, an[2]=hundreds.

Function
REQ-011 SHALL convert binary to BCD by sequential double-dabble: one shift per clk, exactly 8 shift edges per conversion.
REQ-012 SHALL, on edge E0 with value_valid=1 and busy=0, capture value_in and assert busy after E0.
REQ-013 SHALL perform shifts on E1..E8 and commit the result to bcd on E8.
REQ-014 SHALL deassert busy after E8 unless a pending value exists or value_valid=1 at E8; either case SHALL restart at E8 (acting as the new E0) with busy held high.
REQ-015 SHALL store value_in in a single-entry pending register when value_valid=1 while busy=1 before E8.
REQ-016 SHALL replace an occupied pending entry with the newer value and pulse overwrite for one cycle after that edge.
REQ-017 SHALL, at E8 with both pending and value_valid=1, convert value_in, drop the pending entry and pulse overwrite.
REQ-018 SHALL keep bcd unchanged between commits; no partial result SHALL ever appear on bcd.
REQ-019 SHALL scan digits with a prescaler counting 0..SCAN_DIV-1; on wrap, digit index SHALL advance 0->1->2->0.
REQ-020 SHALL drive exactly one an bit low at a time after reset, registered together with seg.
REQ-021 SHALL encode BCD 0-9 on seg as standard 7-segment glyphs; codes 10-15 SHALL blank (7'h7F).
REQ-022 SHALL blank leading zeros: hundreds blank if 0; tens blank if hundreds=0 and tens=0; ones SHALL always show.
REQ-023 SHALL read bcd for display, so a commit SHALL change the glyph of the active digit on the next output update.

Reset
REQ-024 SHALL, on reset, set busy=0, overwrite=0, bcd=12'h000, pending empty, shift counter 0, prescaler 0, digit index 0.
REQ-025 SHALL drive seg=7'h7F and an=3'b111 during reset and in the first cycle after reset; scanning SHALL begin from ones.
REQ-026 SHALL abort any conversion in progress on reset, leaving bcd=0 with no commit.
REQ-027 SHALL ignore value_valid in any cycle where reset=1.

Structure
REQ-028 SHALL place NUM_DIGITS=3, the 10-entry segment glyph table and SEG_BLANK in a shared package output_display_pkg.
REQ-029 SHALL implement the converter as sub-module bin2bcd_seq (start, bin[7:0], busy, done, bcd[11:0]); scan, blanking and pending logic SHALL stay in output_display.

Verification
REQ-030 SHALL cover: value 8'd255 strobed once -> busy high 8 cycles, bcd=12'h255 after E8, glyphs 2,5,5.
REQ-031 SHALL cover: value 8'd7 -> bcd=12'h007; an[2] and an[1] phases show seg=7'h7F; ones shows 7.
REQ-032 SHALL cover: strobe 13 at E0, 21 at E3, 34 at E5 -> one overwrite pulse after E5; bcd=0x013 after E8, then 0x034 eight cycles later; 21 is never committed.
REQ-033 SHALL cover: strobe 1 at E0, then 2 at both E4 and E8 -> overwrite pulse after E8; bcd=0x001 committed at E8; 2 is the value being converted after E8.
REQ-034 SHALL cover: reset asserted at E4 of conversion of 200 -> bcd=0, busy=0, an=3'b111 the cycle after reset deasserts; a fresh strobe of 200 then converts correctly.
REQ-035 SHALL cover: SCAN_DIV=2, value 8'd144 -> an sequence 110,101,011 repeating every 6 cycles with glyphs 4,4,1.
